pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Sequences every change of fetch PC in the out-of-order core.
- Accepts redirect requests from two requesters:
  - decode: jumps and taken branches, with the target already computed by the next-instruction address logic;
  - commit: mispredict or exception recovery.
- For jump-register (jr/jalr), waits until the source register value is ready.
- Arbitrates the two requesters (commit always wins), holds one redirect until fetch accepts it, then drives a fetch-flush window.

Parameters:
- FLUSH_CYCLES, 2, number of cycles Fetch_Flush stays high after fetch accepts a redirect (0 allowed).
- CNT_W, 3, width of the flush counter; must satisfy 2^CNT_W > FLUSH_CYCLES.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Dec_Valid  in  1  decode presents an instruction this cycle.
- Dec_Jump  in  1  instruction is j/jal/jr/jalr.
- Dec_JumpRegister  in  1  instruction is jr/jalr; meaningful only with Dec_Jump.
- Dec_BranchTaken  in  1  conditional branch resolved taken at decode.
- Dec_Target  in  32  computed jump/branch destination; ignored for jr/jalr.
- Dec_Reg  in  5  jr/jalr source register number.
- Reg_Ready  in  1  register file/bypass holds a valid value for the watched register.
- Reg_Value  in  32  that register value.
- Commit_Redirect  in  1  commit-stage recovery request; single-cycle pulse.
- Commit_Target  in  32  recovery PC.
- Fetch_Ack  in  1  fetch accepted Redirect_Addr this cycle.
- Redirect_Valid  out  1  redirect pending toward fetch.
- Redirect_Addr  out  32  target PC; stable while Redirect_Valid is high.
- Redirect_Source  out  1  0 = decode, 1 = commit.
- Redirect_Misaligned  out  1  Redirect_Addr[1:0] != 0; valid when Redirect_Valid is high.
- Decode_Stall  out  1  decode must hold; high whenever state != IDLE.
- Fetch_Flush  out  1  fetch discards in-flight instructions.
- Watch_Reg  out  5  register awaited in JR_WAIT.

Behaviour:
- States: IDLE, JR_WAIT, ISSUE, FLUSH. All outputs are registered.
- Reset values: state IDLE, all 1-bit outputs 0, Redirect_Addr 0, Watch_Reg 0, flush counter 0. RESET overrides everything, including a pending ISSUE or an active FLUSH.
- The decode request that triggers a transition is consumed in that cycle. Decode_Stall takes effect from the next cycle.
- IDLE, priority order:
  1. Commit_Redirect: latch Commit_Target, Source=1, go ISSUE.
  2. Dec_Valid & ((Dec_Jump & !Dec_JumpRegister) | Dec_BranchTaken): latch Dec_Target, Source=0, go ISSUE.
  3. Dec_Valid & Dec_Jump & Dec_JumpRegister & Reg_Ready: latch Reg_Value, Source=0, go ISSUE.
  4. Same as 3 but !Reg_Ready: latch Dec_Reg into Watch_Reg, go JR_WAIT.
  5. Otherwise stay IDLE.
- JR_WAIT:
  - Commit_Redirect aborts the jr: latch Commit_Target, Source=1, go ISSUE.
  - Else Reg_Ready: latch Reg_Value, go ISSUE.
  - Else stay; no timeout.
- ISSUE:
  - Redirect_Valid=1 from the first cycle in ISSUE; Redirect_Addr and Redirect_Source are held constant.
  - Commit_Redirect while Source=0: overwrite address with Commit_Target, set Source=1, stay ISSUE. Fetch_Ack in that same cycle is ignored.
  - Commit_Redirect while Source=1: replace address with the newer Commit_Target; same ack rule.
  - Fetch_Ack without commit: drop Redirect_Valid next cycle. Load counter with FLUSH_CYCLES and go FLUSH; if FLUSH_CYCLES=0, go IDLE.
- FLUSH:
  - Fetch_Flush=1 for exactly FLUSH_CYCLES cycles, then IDLE.
  - Commit_Redirect during FLUSH: latch Commit_Target, Source=1, go ISSUE immediately; Fetch_Flush drops.
  - Decode requests are ignored outside IDLE.
- Minimum latency:
  - decode j → Redirect_Valid: 1 cycle;
  - ack → Fetch_Flush high: 1 cycle;
  - ack → next redirect accepted: FLUSH_CYCLES+1 cycles.
- No arithmetic is performed; addresses pass through unmodified, and misalignment is only flagged.

Optional Feature:
- REDIRECT_TRACE_EN defined: on each transition into ISSUE, $display the source, the target, Watch_Reg and Reg_Value for jr.
  - Format: "Redirect: src=%d reg[%d] => %x"
  - Also warn when Redirect_Misaligned is set.
- Undefined: no simulation output; RTL is functionally identical.

Test Plan:
- Reset, then Dec_Valid+Dec_Jump, Dec_Target=0x00400100 → next cycle Redirect_Valid=1, Addr=0x00400100, Source=0, Decode_Stall=1. Ack → Fetch_Flush high for 2 cycles, then IDLE, stall low.
- jr with Reg_Ready=0, Dec_Reg=31 → JR_WAIT with Watch_Reg=31, no Redirect_Valid. Reg_Ready=1, Reg_Value=0x00400040 at cycle 5 → Redirect_Valid at cycle 6 with Addr=0x00400040.
- Same cycle: Commit_Redirect (0x80000180) and decode jump (0x00400100) → Addr=0x80000180, Source=1; the decode jump is dropped.
- ISSUE holding decode target 0x00400100; Commit_Redirect=0x00400200 together with Fetch_Ack → ack ignored, Addr=0x00400200, Source=1, Redirect_Valid stays 1 until the next ack.
- jr with Reg_Value=0x00400042 → Redirect_Misaligned=1. Then RESET asserted during FLUSH → all outputs 0 next cycle.
- FLUSH_CYCLES=0 build: ack → IDLE next cycle, Fetch_Flush never asserted.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC redirect sequencer: arbitrates decode/commit redirects, waits on jr sources, drives a flush window.
// Optional trace output is enabled by defining REDIRECT_TRACE_EN.
module pc_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Dec_Valid,
  input  logic        Dec_Jump,
  input  logic        Dec_JumpRegister,
  input  logic        Dec_BranchTaken,
  input  logic [31:0] Dec_Target,
  input  logic [4:0]  Dec_Reg,
  input  logic        Reg_Ready,
  input  logic [31:0] Reg_Value,
  input  logic        Commit_Redirect,
  input  logic [31:0] Commit_Target,
  input  logic        Fetch_Ack,
  output logic        Redirect_Valid,
  output logic [31:0] Redirect_Addr,
  output logic        Redirect_Source,
  output logic        Redirect_Misaligned,
  output logic        Decode_Stall,
  output logic        Fetch_Flush,
  output logic [4:0]  Watch_Reg
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_JR_WAIT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                src_q, src_d;
  logic [REG_W-1:0]    watch_q, watch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                mis_q, mis_d;
  logic                stall_q, stall_d;
  logic                flush_q, flush_d;

  logic dec_direct_c;
  logic dec_jr_c;

  assign dec_direct_c = Dec_Valid & ((Dec_Jump & ~Dec_JumpRegister) | Dec_BranchTaken);
  assign dec_jr_c     = Dec_Valid & Dec_Jump & Dec_JumpRegister;

  // Next-state and registered-output computation; commit always has priority.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    src_d   = src_q;
    watch_d = watch_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (Commit_Redirect) begin
          addr_d  = Commit_Target;
          src_d   = 1'b1;
          state_d = ST_ISSUE;
        end else if (dec_direct_c) begin
          addr_d  = Dec_Target;
          src_d   = 1'b0;
          state_d = ST_ISSUE;
        end else if (dec_jr_c && Reg_Ready) begin
          addr_d  = Reg_Value;
          src_d   = 1'b0;
          state_d = ST_ISSUE;
        end else if (dec_jr_c) begin
          watch_d = Dec_Reg;
          state_d = ST_JR_WAIT;
        end
      end
      ST_JR_WAIT: begin
        if (Commit_Redirect) begin
          addr_d  = Commit_Target;
          src_d   = 1'b1;
          state_d = ST_ISSUE;
        end else if (Reg_Ready) begin
          addr_d  = Reg_Value;
          src_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A same-cycle ack is discarded so fetch always sees the newest commit target.
        if (Commit_Redirect) begin
          addr_d = Commit_Target;
          src_d  = 1'b1;
        end else if (Fetch_Ack) begin
          cnt_d   = CNT_W'(FLUSH_CYCLES);
          state_d = (FLUSH_CYCLES == 0) ? ST_IDLE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (Commit_Redirect) begin
          addr_d  = Commit_Target;
          src_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_ISSUE);
    stall_d = (state_d != ST_IDLE);
    flush_d = (state_d == ST_FLUSH);
    mis_d   = valid_d & (addr_d[1:0] != 2'b00);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      src_q   <= 1'b0;
      watch_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      watch_q <= watch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

`ifdef REDIRECT_TRACE_EN
  // Log each entry into ISSUE; for a jr the target is the register value.
  always_ff @(posedge CLK) begin
    if (!RESET && state_d == ST_ISSUE && state_q != ST_ISSUE) begin
      $display("Redirect: src=%d reg[%d] => %x", src_d, watch_d, addr_d);
      if (mis_d) $warning("Redirect target %x is misaligned", addr_d);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

  assign Redirect_Valid      = valid_q;
  assign Redirect_Addr       = addr_q;
  assign Redirect_Source     = src_q;
  assign Redirect_Misaligned = mis_q;
  assign Decode_Stall        = stall_q;
  assign Fetch_Flush         = flush_q;
  assign Watch_Reg           = watch_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: per-cycle vector table with a scoreboard queue,
// hand sequences for a long jr wait and a FLUSH_CYCLES=0 instance.
module tb_pc_redirect_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic        rst;
    logic        dv;
    logic        j;
    logic        jr;
    logic        bt;
    logic [31:0] dt;
    logic [4:0]  dreg;
    logic        rr;
    logic [31:0] rv;
    logic        cr;
    logic [31:0] ct;
    logic        ack;
    logic        ev;
    logic [31:0] ea;
    logic        es;
    logic        em;
    logic        estall;
    logic        eflush;
    logic        cw;
    logic [4:0]  ew;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv, j, jr, bt, rr, cr, ack;
  logic [31:0] dt, rv, ct;
  logic [4:0]  dreg;
  logic        o_valid, o_src, o_mis, o_stall, o_flush;
  logic [31:0] o_addr;
  logic [4:0]  o_watch;

  logic        z_dv, z_cr, z_ack;
  logic        z_valid, z_src, z_mis, z_stall, z_flush;
  logic [31:0] z_addr;
  logic [4:0]  z_watch;
  logic        z_flush_seen = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(3)) dut (
    .CLK(clk), .RESET(rst),
    .Dec_Valid(dv), .Dec_Jump(j), .Dec_JumpRegister(jr), .Dec_BranchTaken(bt),
    .Dec_Target(dt), .Dec_Reg(dreg), .Reg_Ready(rr), .Reg_Value(rv),
    .Commit_Redirect(cr), .Commit_Target(ct), .Fetch_Ack(ack),
    .Redirect_Valid(o_valid), .Redirect_Addr(o_addr), .Redirect_Source(o_src),
    .Redirect_Misaligned(o_mis), .Decode_Stall(o_stall), .Fetch_Flush(o_flush),
    .Watch_Reg(o_watch)
  );

  pc_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(1)) dut0 (
    .CLK(clk), .RESET(rst),
    .Dec_Valid(z_dv), .Dec_Jump(j), .Dec_JumpRegister(jr), .Dec_BranchTaken(bt),
    .Dec_Target(dt), .Dec_Reg(dreg), .Reg_Ready(rr), .Reg_Value(rv),
    .Commit_Redirect(z_cr), .Commit_Target(ct), .Fetch_Ack(z_ack),
    .Redirect_Valid(z_valid), .Redirect_Addr(z_addr), .Redirect_Source(z_src),
    .Redirect_Misaligned(z_mis), .Decode_Stall(z_stall), .Fetch_Flush(z_flush),
    .Watch_Reg(z_watch)
  );

  always @(posedge clk) if (z_flush === 1'b1) z_flush_seen <= 1'b1;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; dv = v.dv; j = v.j; jr = v.jr; bt = v.bt; dt = v.dt; dreg = v.dreg;
    rr = v.rr; rv = v.rv; cr = v.cr; ct = v.ct; ack = v.ack;
  endtask

  task automatic idle_inputs();
    rst = 0; dv = 0; j = 0; jr = 0; bt = 0; dt = '0; dreg = '0; rr = 0; rv = '0;
    cr = 0; ct = '0; ack = 0; z_dv = 0; z_cr = 0; z_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rst dv j jr bt dt dreg rr rv cr ct ack | ev ea es em stall flush cw ew
  task automatic add(input logic r, input logic v_, input logic j_, input logic jr_, input logic bt_,
                     input logic [31:0] dt_, input logic [4:0] dreg_, input logic rr_, input logic [31:0] rv_,
                     input logic cr_, input logic [31:0] ct_, input logic ack_,
                     input logic ev, input logic [31:0] ea, input logic es, input logic em,
                     input logic st, input logic fl, input logic cw, input logic [4:0] ew);
    vec_t t;
    t.rst = r; t.dv = v_; t.j = j_; t.jr = jr_; t.bt = bt_; t.dt = dt_; t.dreg = dreg_;
    t.rr = rr_; t.rv = rv_; t.cr = cr_; t.ct = ct_; t.ack = ack_;
    t.ev = ev; t.ea = ea; t.es = es; t.em = em; t.estall = st; t.eflush = fl; t.cw = cw; t.ew = ew;
    tbl.push_back(t);
  endtask

  initial begin
    vec_t e;
    int   waited;
    int   flush_cnt;
    logic wait_ok;

    // reset, then plain jump with ack and 2-cycle flush; decode during FLUSH ignored
    add(H,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,H,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    add(L,H,H,L,L,32'h00400100,5'd0,L,32'h0,L,32'h0,L,  H,32'h00400100,L,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  H,32'h00400100,L,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,H,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,H,H,L,L,32'h00001234,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    // jr waits on r31, then resolves
    add(L,H,H,H,L,32'h0,5'd31,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,L,H,5'd31);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,L,H,5'd31);
    add(L,L,L,L,L,32'h0,5'd0,H,32'h00400040,L,32'h0,L,  H,32'h00400040,L,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,H,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    // commit and decode jump together: commit wins
    add(L,H,H,L,L,32'h00400100,5'd0,L,32'h0,H,32'h80000180,L,  H,32'h80000180,H,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,H,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    // taken branch, then commit with same-cycle ack (ack ignored), newer commit, commit in FLUSH
    add(L,H,L,L,H,32'h00400100,5'd0,L,32'h0,L,32'h0,L,  H,32'h00400100,L,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,H,32'h00400200,H,  H,32'h00400200,H,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  H,32'h00400200,H,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,H,32'h00400300,L,  H,32'h00400300,H,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,H,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,H,32'h00400400,L,  H,32'h00400400,H,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,H,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    // misaligned jr target, then reset during FLUSH
    add(L,H,H,H,L,32'h0,5'd5,H,32'h00400042,L,32'h0,L,  H,32'h00400042,L,H,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,H,  L,32'h0,L,L,H,H,L,5'd0);
    add(H,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,H,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    // commit aborts a waiting jr
    add(L,H,H,H,L,32'h0,5'd7,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,L,H,5'd7);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,H,32'h80000000,L,  H,32'h80000000,H,L,H,L,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,H,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,H,H,L,5'd0);
    add(L,L,L,L,L,32'h0,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    // non-redirecting decode traffic
    add(L,H,L,L,L,32'h00400500,5'd0,L,32'h0,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);
    add(L,H,L,H,L,32'h00400500,5'd3,H,32'h00400600,L,32'h0,L,  L,32'h0,L,L,L,L,L,5'd0);

    idle_inputs();
    rst = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      step();
      e = exp_q.pop_front();
      chk("valid", i, 32'(o_valid), 32'(e.ev));
      chk("stall", i, 32'(o_stall), 32'(e.estall));
      chk("flush", i, 32'(o_flush), 32'(e.eflush));
      chk("misaligned", i, 32'(o_mis), 32'(e.em));
      if (e.ev) begin
        chk("addr", i, o_addr, e.ea);
        chk("source", i, 32'(o_src), 32'(e.es));
      end
      if (e.cw) chk("watch_reg", i, 32'(o_watch), 32'(e.ew));
    end

    // long jr wait: no redirect while the register stays unready, then 1-cycle resolve
    idle_inputs();
    dv = 1; j = 1; jr = 1; dreg = 5'd12;
    step();
    idle_inputs();
    chk("jrw_watch", 100, 32'(o_watch), 32'd12);
    wait_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_valid !== 1'b0 || o_stall !== 1'b1) wait_ok = 1'b0;
    end
    chk("jrw_hold", 101, 32'(wait_ok), 32'd1);
    rr = 1; rv = 32'h00400abc;
    step();
    idle_inputs();
    chk("jrw_valid", 102, 32'(o_valid), 32'd1);
    chk("jrw_addr", 103, o_addr, 32'h00400abc);
    ack = 1;
    step();
    idle_inputs();
    flush_cnt = 0;
    waited = 0;
    while (o_stall === 1'b1 && waited < 10) begin
      if (o_flush === 1'b1) flush_cnt++;
      step();
      waited++;
    end
    chk("jrw_idle_reached", 104, 32'(o_stall), 32'd0);
    chk("jrw_flush_len", 105, 32'(flush_cnt), 32'd2);

    // FLUSH_CYCLES=0 instance: ack returns straight to IDLE with no flush
    idle_inputs();
    z_dv = 1; j = 1; dt = 32'h00400800;
    step();
    idle_inputs();
    chk("z_valid", 200, 32'(z_valid), 32'd1);
    chk("z_addr", 201, z_addr, 32'h00400800);
    chk("z_stall", 202, 32'(z_stall), 32'd1);
    z_ack = 1;
    step();
    idle_inputs();
    chk("z_valid_drop", 203, 32'(z_valid), 32'd0);
    chk("z_stall_drop", 204, 32'(z_stall), 32'd0);
    chk("z_flush_now", 205, 32'(z_flush), 32'd0);
    z_dv = 1; j = 1; dt = 32'h00400900;
    step();
    idle_inputs();
    chk("z_next_accept", 206, z_addr, 32'h00400900);
    z_ack = 1;
    step();
    idle_inputs();
    step();
    chk("z_flush_never", 207, 32'(z_flush_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
